// File: rtl/multisim_apb_arbiter.sv
// -----------------------------------------------------------------------------
// multisim_apb_arbiter
//   Round-robin arbiter that lets NUM_REQ upstream APB managers share one
//   downstream APB manager port. A typical target is a single multisim APB push
//   client. Only one downstream transfer is in flight at a time. Its pready and
//   response are routed back to the granted requester only.
//
//   Optional feature: define MULTISIM_APB_ARB_LOCK_EN to add the i_lock port.
//   A requester that completes with its lock bit set is re-granted straight
//   away, as long as it still holds psel in the following IDLE cycle.
//
// Parameters
//   NUM_REQ  number of upstream requesters (>=1)
//   REQ_W    width of the opaque APB request payload (addr/wdata/write/...)
//   RESP_W   width of the opaque APB response payload (rdata/pslverr/...)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_apb_s_req       per-requester request payload
//   i_apb_s_psel      per-requester psel
//   i_apb_s_penable   per-requester penable (the phase is implied by psel)
//   o_apb_s_pready    per-requester pready; only the granted one can be set
//   o_apb_s_resp      per-requester response; '0 unless that pready is set
//   o_apb_m_req       downstream request payload ('0 in IDLE)
//   o_apb_m_psel      downstream psel
//   o_apb_m_penable   downstream penable
//   i_apb_m_pready    downstream pready; ignored outside ACCESS
//   i_apb_m_resp      downstream response payload
//   o_grant           one-hot current grant; 0 in IDLE
//   i_lock            (MULTISIM_APB_ARB_LOCK_EN only) per-requester lock
// -----------------------------------------------------------------------------

// Per-requester return path. The response is forwarded only on the completing
// cycle of this lane's own grant, and only if the lane still holds psel.
module multisim_apb_arbiter_lane #(
  parameter int RESP_W = 32
) (
  input  logic              done,
  input  logic              grant,
  input  logic              psel,
  input  logic [RESP_W-1:0] m_resp,
  output logic              pready,
  output logic [RESP_W-1:0] resp
);
  assign pready = done & grant & psel;
  assign resp   = pready ? m_resp : '0;
endmodule

module multisim_apb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 64,
  parameter int RESP_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0][REQ_W-1:0]  i_apb_s_req,
  input  logic [NUM_REQ-1:0]             i_apb_s_psel,
  input  logic [NUM_REQ-1:0]             i_apb_s_penable,
  output logic [NUM_REQ-1:0]             o_apb_s_pready,
  output logic [NUM_REQ-1:0][RESP_W-1:0] o_apb_s_resp,
  output logic [REQ_W-1:0]               o_apb_m_req,
  output logic                           o_apb_m_psel,
  output logic                           o_apb_m_penable,
  input  logic                           i_apb_m_pready,
  input  logic [RESP_W-1:0]              i_apb_m_resp,
  output logic [NUM_REQ-1:0]             o_grant
`ifdef MULTISIM_APB_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]             i_lock
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic               done;
`ifdef MULTISIM_APB_ARB_LOCK_EN
  logic               lock_q, lock_d;
`endif

  // The arbiter sequences the transfer on psel alone. Upstream penable is only
  // sampled into a reduction so it is visibly consumed.
  logic penable_unused;
  assign penable_unused = ^i_apb_s_penable;

  // Round-robin scan starting at ptr. The loop runs from the far end, so the
  // index closest to ptr is the last one written and wins. This avoids a break.
  always_comb begin
    int s;
    s       = 0;
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = int'(ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (i_apb_s_psel[s]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(s);
      end
    end
`ifdef MULTISIM_APB_ARB_LOCK_EN
    // A locked requester that is still asking takes the bus back.
    // gidx_q still holds its index, because gidx is never cleared.
    if (lock_q && i_apb_s_psel[gidx_q]) begin
      win_vld = 1'b1;
      win_idx = gidx_q;
    end
`endif
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gidx_d          = gidx_q;
    grant_d         = grant_q;
    o_apb_m_psel    = 1'b0;
    o_apb_m_penable = 1'b0;
    done            = 1'b0;
`ifdef MULTISIM_APB_ARB_LOCK_EN
    lock_d          = lock_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MULTISIM_APB_ARB_LOCK_EN
        // A lock applies to the first IDLE cycle after completion only.
        lock_d = 1'b0;
`endif
        if (win_vld) begin
          gidx_d           = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          state_d          = SETUP;
        end
      end
      SETUP: begin
        o_apb_m_psel = 1'b1;
        state_d      = ACCESS;
      end
      ACCESS: begin
        o_apb_m_psel    = 1'b1;
        o_apb_m_penable = 1'b1;
        if (i_apb_m_pready) begin
          done    = 1'b1;
          grant_d = '0;
          state_d = IDLE;
          // The pointer always moves past the finishing requester, even if its
          // psel dropped early. A lock re-grant does not move the pointer.
          // When the locked chain ends, the scan resumes just after g.
          ptr_d   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
`ifdef MULTISIM_APB_ARB_LOCK_EN
          lock_d  = i_lock[gidx_q];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
`ifdef MULTISIM_APB_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
`ifdef MULTISIM_APB_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign o_grant     = grant_q;
  assign o_apb_m_req = (state_q != IDLE) ? i_apb_s_req[gidx_q] : '0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    multisim_apb_arbiter_lane #(.RESP_W(RESP_W)) u_lane (
      .done   (done),
      .grant  (grant_q[i]),
      .psel   (i_apb_s_psel[i]),
      .m_resp (i_apb_m_resp),
      .pready (o_apb_s_pready[i]),
      .resp   (o_apb_s_resp[i])
    );
  end

endmodule
